// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the parity-select helper,
// kept common so the matching receiver computes parity identically.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_SEL_EVEN = 1'b0;
  localparam logic PARITY_SEL_ODD  = 1'b1;

  // Even parity makes the total count of ones even; odd inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic sel);
    logic p;
    p = ^data;
    if (sel == PARITY_SEL_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side byte handshake and serial/status signals of the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 8
) ();

  logic                          i_TX_Valid;
  logic [7:0]                    i_TX_Byte;
  logic                          o_TX_Ready;
  logic                          o_TX_Serial;
  logic                          o_TX_Active;
  logic                          o_TX_Done;
  logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count;

  modport master (
    output i_TX_Valid, i_TX_Byte,
    input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
  );

  modport slave (
    input  i_TX_Valid, i_TX_Byte,
    output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with fall-through read data and a registered ready flag that
// mirrors "not full" and is held low while in reset.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_ready,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_ready;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // Occupancy flags and next count; simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_full    = (r_count == COUNT_FULL);
    w_empty   = (r_count == {CW{1'b0}});
    w_do_push = i_push & ~w_full;
    w_do_pop  = i_pop & ~w_empty;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage, pointers, count and the registered ready flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ready  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != COUNT_FULL);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8-bit serialiser with optional
// parity and one or two stop bits; consecutive queued bytes go out with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_tx_buffered_if.slave  tx_if
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_SEL   = (PARITY_ODD != 0) ? PARITY_SEL_ODD : PARITY_SEL_EVEN;

  localparam logic [2:0] S_IDLE   = 3'(TX_IDLE);
  localparam logic [2:0] S_START  = 3'(TX_START);
  localparam logic [2:0] S_DATA   = 3'(TX_DATA);
  localparam logic [2:0] S_PARITY = 3'(TX_PARITY);
  localparam logic [2:0] S_STOP   = 3'(TX_STOP);
  localparam logic [2:0] S_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_serial;
  logic          r_active;
  logic          r_stop_end;
  logic          r_done;

  logic [7:0]    w_head;
  logic          w_ready;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic          w_stop_end;
  logic          w_line;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_Clock),
    .i_rst_n (i_Rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (tx_if.i_TX_Byte),
    .o_data  (w_head),
    .o_ready (w_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Bit timing, pop decision and the line level implied by the current state.
  always_comb begin
    w_push     = tx_if.i_TX_Valid & w_ready & ~w_full;
    w_bit_end  = (r_baud == BAUD_LAST);
    w_stop_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == STOP_LAST);
    w_pop      = ((r_state == S_IDLE) || w_stop_end) && !w_empty;
    case (r_state)
      S_IDLE:   w_line = 1'b1;
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[r_bit_idx];
      S_PARITY: w_line = r_parity;
      S_STOP:   w_line = 1'b1;
      default:  w_line = 1'b1;
    endcase
  end

  // Frame sequencer: baud counter, bit index and state; loads the next byte on pop.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= {BW{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shift  <= w_head;
        r_parity <= parity_bit(w_head, PAR_SEL);
      end else begin
        r_shift  <= r_shift;
        r_parity <= r_parity;
      end
      case (r_state)
        S_IDLE: begin
          r_baud    <= {BW{1'b0}};
          r_bit_idx <= 3'd0;
          r_state   <= w_pop ? S_START : S_IDLE;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_AFTER_DATA;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= 3'd0;
            r_state   <= S_STOP;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          // The bit index doubles as the stop-bit counter here.
          if (w_bit_end) begin
            r_baud <= {BW{1'b0}};
            if (w_stop_end) begin
              r_bit_idx <= 3'd0;
              r_state   <= w_pop ? S_START : S_IDLE;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_baud    <= {BW{1'b0}};
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  // Registered outputs, one cycle behind the sequencer; done trails the last stop cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_stop_end <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_serial   <= w_line;
      r_active   <= (r_state != S_IDLE);
      r_stop_end <= w_stop_end;
      r_done     <= r_stop_end;
    end
  end

  assign tx_if.o_TX_Ready   = w_ready;
  assign tx_if.o_TX_Serial  = r_serial;
  assign tx_if.o_TX_Active  = r_active;
  assign tx_if.o_TX_Done    = r_done;
  assign tx_if.o_FIFO_Count = w_count;

endmodule
